// File: rtl/dma_channel_sb_if.sv
// Bus bundle for the Sound Blaster DMA channel: I/O register port, memory
// read port, consumer toggle handshake and terminal-count pulse.
// The master side is the host/system environment; the slave side is the channel.
interface dma_channel_sb_if;
    // I/O register access (toggle strobes)
    logic [11:0] port;
    logic [7:0]  iodin;
    logic [7:0]  iodout;
    logic        iowrin;
    logic        iowrout;
    logic        iordin;
    logic        iordout;

    // Memory read port
    logic [19:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_din;

    // Consumer (DAC path) toggle handshake
    logic [7:0]  dma_dout;
    logic        dma_rdout;
    logic        dma_ackin;

    // Terminal-count pulse
    logic        tc;

    modport master (
        output port, iodin, iowrin, iordin, mem_ack, mem_din, dma_ackin,
        input  iodout, iowrout, iordout, mem_addr, mem_req, dma_dout, dma_rdout, tc
    );

    modport slave (
        input  port, iodin, iowrin, iordin, mem_ack, mem_din, dma_ackin,
        output iodout, iowrout, iordout, mem_addr, mem_req, dma_dout, dma_rdout, tc
    );
endinterface

// File: rtl/dma_channel_sb.sv
// Single 8237-compatible DMA channel doing memory->I/O read transfers for the
// Sound Blaster DAC. Owns its address/count/page registers and the shared
// mask/mode/flip-flop/status ports; fetches one byte at a time from memory and
// hands it to the consumer over a toggle handshake.
module dma_channel_sb #(
    parameter int          CHANNEL   = 1,
    parameter logic [11:0] PAGE_PORT = 12'h083
) (
    input logic             clk,
    input logic             reset_n,
    dma_channel_sb_if.slave bus
);

    localparam logic [11:0] ADDR_PORT = 12'(2 * CHANNEL);
    localparam logic [11:0] CNT_PORT  = 12'(2 * CHANNEL + 1);
    localparam logic [1:0]  CH_SEL    = 2'(CHANNEL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_OFFER,
        S_UPDATE
    } state_t;

    state_t      state;
    logic        ff;
    logic        mask;
    logic        tc_stat;
    logic [5:2]  mode;        // [5] decrement, [4] autoinit, [3:2] transfer type
    logic [3:0]  page;
    logic [15:0] base_addr;
    logic [15:0] cur_addr;
    logic [15:0] base_cnt;
    logic [15:0] cur_cnt;

    logic        wr_ev;
    logic        rd_ev;
    logic        rd_is_chan;
    logic        ff_after_rd;
    logic [15:0] upd_addr;
    logic [15:0] upd_cnt;
    logic        at_tc;
    logic [7:0]  rd_data;

    assign wr_ev       = bus.iowrin ^ bus.iowrout;
    assign rd_ev       = bus.iordin ^ bus.iordout;
    assign rd_is_chan  = (bus.port == ADDR_PORT) || (bus.port == CNT_PORT);
    // A write in the same cycle as a read sees the flip-flop after the read toggled it.
    assign ff_after_rd = (rd_ev && rd_is_chan) ? ~ff : ff;

    assign upd_addr = mode[5] ? (cur_addr - 16'd1) : (cur_addr + 16'd1);
    assign upd_cnt  = cur_cnt - 16'd1;
    assign at_tc    = (cur_cnt == 16'd0);

    assign bus.mem_addr = {page, cur_addr};

    // Read-data mux for the currently addressed I/O port.
    always_comb begin
        // NOTE: default first so every path assigns rd_data and no latch is inferred.
        rd_data = 8'hFF;
        case (bus.port)
            ADDR_PORT: rd_data = ff ? cur_addr[15:8] : cur_addr[7:0];
            CNT_PORT:  rd_data = ff ? cur_cnt[15:8]  : cur_cnt[7:0];
            12'h008: begin
                rd_data          = 8'h00;
                rd_data[CHANNEL] = tc_stat;
            end
            default:   rd_data = 8'hFF;
        endcase
    end

    // I/O read data and strobe shadows, registered every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.iodout  <= 8'h00;
            bus.iowrout <= 1'b0;
            bus.iordout <= 1'b0;
        end else begin
            bus.iodout  <= rd_data;
            bus.iowrout <= bus.iowrin;
            bus.iordout <= bus.iordin;
        end
    end

    // Channel registers and transfer FSM; read side effects, then FSM, then writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            ff            <= 1'b0;
            mask          <= 1'b1;
            tc_stat       <= 1'b0;
            mode          <= '0;
            page          <= '0;
            base_addr     <= '0;
            cur_addr      <= '0;
            base_cnt      <= '0;
            cur_cnt       <= '0;
            bus.mem_req   <= 1'b0;
            bus.dma_dout  <= 8'h00;
            bus.dma_rdout <= 1'b0;
            bus.tc        <= 1'b0;
        end else begin
            bus.tc <= 1'b0;

            if (rd_ev) begin
                if (rd_is_chan)           ff      <= ~ff;
                if (bus.port == 12'h008)  tc_stat <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!mask && mode[3:2] == 2'b10) begin
                        state       <= S_FETCH;
                        bus.mem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        bus.dma_dout  <= bus.mem_din;
                        bus.mem_req   <= 1'b0;
                        bus.dma_rdout <= ~bus.dma_rdout;
                        state         <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (bus.dma_ackin == bus.dma_rdout) state <= S_UPDATE;
                end
                S_UPDATE: begin
                    cur_addr <= upd_addr;
                    cur_cnt  <= upd_cnt;
                    if (at_tc) begin
                        bus.tc  <= 1'b1;
                        tc_stat <= 1'b1;
                        if (mode[4]) begin
                            cur_addr <= base_addr;
                            cur_cnt  <= base_cnt;
                        end else begin
                            mask <= 1'b1;
                        end
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // NOTE: non-blocking updates land in statement order, so a byte written
            // here overrides only those bits of an UPDATE value assigned above.
            if (wr_ev) begin
                case (bus.port)
                    ADDR_PORT: begin
                        if (ff_after_rd) begin
                            base_addr[15:8] <= bus.iodin;
                            cur_addr[15:8]  <= bus.iodin;
                        end else begin
                            base_addr[7:0]  <= bus.iodin;
                            cur_addr[7:0]   <= bus.iodin;
                        end
                        ff <= ~ff_after_rd;
                    end
                    CNT_PORT: begin
                        if (ff_after_rd) begin
                            base_cnt[15:8] <= bus.iodin;
                            cur_cnt[15:8]  <= bus.iodin;
                        end else begin
                            base_cnt[7:0]  <= bus.iodin;
                            cur_cnt[7:0]   <= bus.iodin;
                        end
                        ff <= ~ff_after_rd;
                    end
                    PAGE_PORT: page <= bus.iodin[3:0];
                    12'h00C:   ff   <= 1'b0;
                    12'h00D: begin
                        mask    <= 1'b1;
                        ff      <= 1'b0;
                        tc_stat <= 1'b0;
                    end
                    12'h00A: if (bus.iodin[1:0] == CH_SEL) mask <= bus.iodin[2];
                    12'h00F: mask <= bus.iodin[CHANNEL];
                    12'h00B: if (bus.iodin[1:0] == CH_SEL) mode <= bus.iodin[5:2];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_channel_sb.sv
// Directed self-checking bench for dma_channel_sb (CHANNEL=1, page port 0x083).
// The bench plays host, memory and consumer; expected values are hand-computed.
module tb_dma_channel_sb;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic exp_rd;     // expected level of dma_rdout, toggled once per fetched byte

    dma_channel_sb_if bus();

    dma_channel_sb #(
        .CHANNEL   (1),
        .PAGE_PORT (12'h083)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound in case a fault stalls the sequence.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus helpers (all called at a negedge) ----------------
    task automatic io_write(input logic [11:0] p, input logic [7:0] d);
        bus.port   = p;
        bus.iodin  = d;
        bus.iowrin = ~bus.iowrin;
        @(negedge clk);
    endtask

    task automatic io_read(input logic [11:0] p, output logic [7:0] v);
        bus.port   = p;
        bus.iordin = ~bus.iordin;
        @(negedge clk);
        v = bus.iodout;
    endtask

    task automatic wait_req(output bit got, output logic [19:0] addr);
        got  = 1'b0;
        addr = 'x;
        for (int i = 0; i < 50; i++) begin
            if (bus.mem_req) begin
                got  = 1'b1;
                addr = bus.mem_addr;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_offer(input logic [7:0] d, output logic [7:0] dout,
                             output logic rdout, output logic req);
        bus.mem_din = d;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        exp_rd      = ~exp_rd;
        dout        = bus.dma_dout;
        rdout       = bus.dma_rdout;
        req         = bus.mem_req;
    endtask

    task automatic consume(output logic tc_out);
        bus.dma_ackin = exp_rd;
        @(negedge clk);
        @(negedge clk);
        tc_out = bus.tc;
    endtask

    task automatic count_req(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b0) hits++;
        end
    endtask

    task automatic program_channel(input logic [15:0] addr, input logic [15:0] cnt,
                                   input logic [7:0] mode);
        io_write(12'h00D, 8'h00);
        io_write(12'h083, 8'h02);
        io_write(12'h002, addr[7:0]);
        io_write(12'h002, addr[15:8]);
        io_write(12'h003, cnt[7:0]);
        io_write(12'h003, cnt[15:8]);
        io_write(12'h00B, mode);
        io_write(12'h00A, 8'h01);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] v;
        bus.port = '0; bus.iodin = '0; bus.iowrin = 1'b0; bus.iordin = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_din = '0; bus.dma_ackin = 1'b0;
        exp_rd  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.iodout, bus.iowrout, bus.iordout, bus.mem_req} !== 11'd0) begin
            errors++;
            $display("FAIL reset_io: iodout=%02h iowrout=%b iordout=%b mem_req=%b, all must be 0",
                     bus.iodout, bus.iowrout, bus.iordout, bus.mem_req);
        end
        checks++;
        if ({bus.mem_addr, bus.dma_dout, bus.dma_rdout, bus.tc} !== 30'd0) begin
            errors++;
            $display("FAIL reset_dma: mem_addr=%05h dma_dout=%02h dma_rdout=%b tc=%b, all must be 0",
                     bus.mem_addr, bus.dma_dout, bus.dma_rdout, bus.tc);
        end
        reset_n = 1'b1;
        @(negedge clk);
        io_read(12'h002, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr_reg: got %02h expected 00", v);
        end
        io_read(12'h008, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: got %02h expected 00", v);
        end
        io_write(12'h00C, 8'h00);
    endtask

    task automatic test_single_block();
        logic [19:0] exp_a [4] = '{20'h21234, 20'h21235, 20'h21236, 20'h21237};
        bit          got;
        logic [19:0] a;
        logic [7:0]  dout, v, d;
        logic        rd, req, t;
        int          hits;
        io_write(12'h083, 8'h02);
        io_write(12'h00C, 8'h00);
        io_write(12'h002, 8'h34);
        io_write(12'h002, 8'h12);
        io_write(12'h003, 8'h03);
        io_write(12'h003, 8'h00);
        io_write(12'h00B, 8'h49);
        io_write(12'h00A, 8'h01);
        for (int i = 0; i < 4; i++) begin
            d = 8'hA0 + 8'(i);
            wait_req(got, a);
            checks++;
            if (!got || a !== exp_a[i]) begin
                errors++;
                $display("FAIL single_addr[%0d]: mem_addr=%05h req_seen=%0d expected %05h", i, a, got, exp_a[i]);
            end
            ack_offer(d, dout, rd, req);
            checks++;
            if (dout !== d || rd !== exp_rd || req !== 1'b0) begin
                errors++;
                $display("FAIL single_offer[%0d]: dout=%02h rdout=%b req=%b expected %02h %b 0", i, dout, rd, req, d, exp_rd);
            end
            consume(t);
            checks++;
            if (t !== (i == 3)) begin
                errors++;
                $display("FAIL single_tc[%0d]: tc=%b expected %b", i, t, (i == 3));
            end
        end
        count_req(20, hits);
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL single_masked: mem_req high %0d cycles after tc, expected 0", hits);
        end
        io_read(12'h002, v);
        checks++;
        if (v !== 8'h38) begin errors++; $display("FAIL single_addr_lo: got %02h expected 38", v); end
        io_read(12'h002, v);
        checks++;
        if (v !== 8'h12) begin errors++; $display("FAIL single_addr_hi: got %02h expected 12", v); end
        io_read(12'h003, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("FAIL single_cnt_lo: got %02h expected FF", v); end
        io_read(12'h003, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("FAIL single_cnt_hi: got %02h expected FF", v); end
    endtask

    task automatic test_status();
        logic [7:0] v;
        io_read(12'h008, v);
        checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL status_set: got %02h expected 02", v); end
        io_read(12'h008, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL status_clear: got %02h expected 00", v); end
        io_read(12'h055, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("FAIL other_port: got %02h expected FF", v); end
    endtask

    task automatic test_autoinit();
        logic [19:0] exp_a [3] = '{20'h21234, 20'h21235, 20'h21234};
        logic        exp_t [3] = '{1'b0, 1'b1, 1'b0};
        bit          got;
        logic [19:0] a;
        logic [7:0]  dout, d;
        logic        rd, req, t;
        int          hits;
        program_channel(16'h1234, 16'h0001, 8'h59);
        for (int i = 0; i < 3; i++) begin
            d = 8'h50 + 8'(i);
            wait_req(got, a);
            checks++;
            if (!got || a !== exp_a[i]) begin
                errors++;
                $display("FAIL auto_addr[%0d]: mem_addr=%05h req_seen=%0d expected %05h", i, a, got, exp_a[i]);
            end
            // Mask the channel while the reloaded block's first fetch is pending.
            if (i == 2) io_write(12'h00A, 8'h05);
            ack_offer(d, dout, rd, req);
            checks++;
            if (dout !== d || rd !== exp_rd || req !== 1'b0) begin
                errors++;
                $display("FAIL auto_offer[%0d]: dout=%02h rdout=%b req=%b expected %02h %b 0", i, dout, rd, req, d, exp_rd);
            end
            consume(t);
            checks++;
            if (t !== exp_t[i]) begin
                errors++;
                $display("FAIL auto_tc[%0d]: tc=%b expected %b", i, t, exp_t[i]);
            end
        end
        count_req(20, hits);
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL auto_mask_in_fetch: mem_req high %0d cycles, expected 0", hits);
        end
    endtask

    task automatic test_decrement();
        logic [19:0] exp_a [2] = '{20'h20000, 20'h2FFFF};
        bit          got;
        logic [19:0] a;
        logic [7:0]  dout, d, v;
        logic        rd, req, t;
        int          hits;
        program_channel(16'h0000, 16'h0001, 8'h69);
        for (int i = 0; i < 2; i++) begin
            d = 8'h70 + 8'(i);
            wait_req(got, a);
            checks++;
            if (!got || a !== exp_a[i]) begin
                errors++;
                $display("FAIL dec_addr[%0d]: mem_addr=%05h req_seen=%0d expected %05h", i, a, got, exp_a[i]);
            end
            ack_offer(d, dout, rd, req);
            checks++;
            if (dout !== d || rd !== exp_rd) begin
                errors++;
                $display("FAIL dec_offer[%0d]: dout=%02h rdout=%b expected %02h %b", i, dout, rd, d, exp_rd);
            end
            consume(t);
            checks++;
            if (t !== (i == 1)) begin
                errors++;
                $display("FAIL dec_tc[%0d]: tc=%b expected %b", i, t, (i == 1));
            end
        end
        count_req(20, hits);
        checks++;
        if (hits != 0) begin errors++; $display("FAIL dec_masked: mem_req high %0d cycles, expected 0", hits); end
        io_write(12'h00C, 8'h00);
        io_read(12'h002, v);
        checks++;
        if (v !== 8'hFE) begin errors++; $display("FAIL dec_addr_lo: got %02h expected FE", v); end
        io_read(12'h002, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("FAIL dec_addr_hi: got %02h expected FF", v); end
    endtask

    task automatic test_stall_and_mask();
        bit          got;
        logic [19:0] a;
        logic [7:0]  dout, v;
        logic        rd, req, t;
        int          bad, hits;
        program_channel(16'h0100, 16'h0005, 8'h49);
        wait_req(got, a);
        checks++;
        if (!got || a !== 20'h20100) begin
            errors++;
            $display("FAIL stall_addr0: mem_addr=%05h req_seen=%0d expected 20100", a, got);
        end
        ack_offer(8'h5A, dout, rd, req);
        checks++;
        if (dout !== 8'h5A || rd !== exp_rd) begin
            errors++;
            $display("FAIL stall_offer: dout=%02h rdout=%b expected 5A %b", dout, rd, exp_rd);
        end
        // Consumer withholds its toggle for 100 cycles.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b0 || bus.dma_dout !== 8'h5A ||
                bus.dma_rdout !== exp_rd || bus.tc !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d cycles with activity while consumer stalled, expected 0", bad);
        end
        consume(t);
        checks++;
        if (t !== 1'b0) begin errors++; $display("FAIL stall_tc: tc=%b expected 0", t); end
        wait_req(got, a);
        checks++;
        if (!got || a !== 20'h20101) begin
            errors++;
            $display("FAIL stall_addr1: mem_addr=%05h req_seen=%0d expected 20101", a, got);
        end
        ack_offer(8'hC3, dout, rd, req);
        checks++;
        if (dout !== 8'hC3 || rd !== exp_rd) begin
            errors++;
            $display("FAIL offer_mask_data: dout=%02h rdout=%b expected C3 %b", dout, rd, exp_rd);
        end
        // Mask the channel while the byte sits in OFFER.
        io_write(12'h00A, 8'h05);
        consume(t);
        count_req(20, hits);
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL offer_mask_stop: mem_req high %0d cycles, expected 0", hits);
        end
        io_write(12'h00C, 8'h00);
        io_read(12'h002, v);
        checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL offer_mask_lo: got %02h expected 02", v); end
        io_read(12'h002, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL offer_mask_hi: got %02h expected 01", v); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_block();
        test_status();
        test_autoinit();
        test_decrement();
        test_stall_and_mask();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
